// File: rtl/down_counter_sync.sv
// -----------------------------------------------------------------------------
// down_counter_sync
//   Synchronous binary down counter with count enable, parallel load, a
//   one-shot stop-at-zero mode and a combinational borrow (terminal count)
//   output for cascading. Used as a timer/delay block.
//
// Parameters
//   WIDTH     counter width in bits (>= 2), default 3
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-high reset
//   en        in   1      count enable
//   load      in   1      parallel load strobe (wins over en)
//   load_val  in   WIDTH  value loaded into Q when load=1
//   oneshot   in   1      1: stop at zero and enter HOLD; 0: wrap around
//   Q         out  WIDTH  registered count value
//   tc        out  1      borrow: en & (Q==0) & COUNT, combinational
//   done      out  1      registered, high while in HOLD
//
// Build option
//   DOWN_CNT_RELOAD_EN  when defined, every load also captures load_val into
//                       an internal reload register, and a free-running wrap
//                       from zero reloads that value (modulus load_val+1).
//                       When undefined, a wrap always goes to all-ones
//                       (modulus 2^WIDTH). Port list is the same in both builds.
// -----------------------------------------------------------------------------
module down_counter_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             done
);

  typedef enum logic {
    COUNT = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] wrap_val;
  logic             count_is_zero;

  assign count_is_zero = (count_reg == '0);

`ifdef DOWN_CNT_RELOAD_EN
  // Reload value for free-running wraps. It resets to all-ones so that,
  // until the first load, this build wraps exactly like the plain build.
  logic [WIDTH-1:0] reload_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_reg <= ALL_ONES;
    end else if (load) begin
      reload_reg <= load_val;
    end
  end

  assign wrap_val = reload_reg;
`else
  assign wrap_val = ALL_ONES;
`endif

  // State, count and done registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= COUNT;
      count_reg <= ALL_ONES;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic. Load overrides everything, including HOLD.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = done_reg;

    if (load) begin
      state_next = COUNT;
      count_next = load_val;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        COUNT: begin
          if (en) begin
            if (!count_is_zero) begin
              count_next = count_reg - ONE;
            end else if (oneshot) begin
              // Stop at zero: Q stays 0, done rises with the state change.
              state_next = HOLD;
              done_next  = 1'b1;
            end else begin
              count_next = wrap_val;
            end
          end
        end
        HOLD: begin
          // Sticky until load or reset; en and oneshot have no effect here.
          count_next = '0;
          done_next  = 1'b1;
        end
        default: begin
          state_next = COUNT;
        end
      endcase
    end
  end

  assign Q    = count_reg;
  assign done = done_reg;
  // Borrow is combinational so a cascaded stage can count on the same edge
  // that this stage wraps.
  assign tc   = en & count_is_zero & (state_reg == COUNT);

endmodule

// File: tb/tb_down_counter_sync.sv
module tb_down_counter_sync;

  localparam int W   = 3;
  localparam int MOD = 1 << W;
`ifdef DOWN_CNT_RELOAD_EN
  localparam bit RELOAD_BUILD = 1'b1;
`else
  localparam bit RELOAD_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         oneshot = 1'b0;
  logic [W-1:0] Q;
  logic         tc;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  down_counter_sync #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .oneshot  (oneshot),
    .Q        (Q),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Behavioural model: count value as an integer, a "stopped" flag, and the
  // remembered modulus base for the reload build.
  int m_q      = MOD - 1;
  bit m_stop   = 1'b0;
  int m_reload = MOD - 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q      = MOD - 1;
      m_stop   = 1'b0;
      m_reload = MOD - 1;
    end else if (load) begin
      m_q      = int'(load_val);
      m_stop   = 1'b0;
      m_reload = int'(load_val);
    end else if (en && !m_stop) begin
      if (m_q > 0)      m_q = m_q - 1;
      else if (oneshot) m_stop = 1'b1;
      else              m_q = RELOAD_BUILD ? m_reload : MOD - 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      $display("t=%0t en=%0b load=%0b val=%0d os=%0b | Q=%0d tc=%0b done=%0b | model Q=%0d stop=%0b",
               $time, en, load, load_val, oneshot, Q, tc, done, m_q, m_stop);
      check("model_Q", int'(Q), m_q);
      check("model_done", int'(done), int'(m_stop));
      check("model_tc", int'(tc), int'(en && (m_q == 0) && !m_stop));
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset asserted from t=1 to t=10.
    #1 reset = 1'b1;
    #2;
    check("reset_Q", int'(Q), 7);
    check("reset_done", int'(done), 0);
    check("reset_tc", int'(tc), 0);
    #7;
    reset = 1'b0;
    en = 1'b1;
    check_en = 1'b1;

    // 1: free count 7 -> 0, then wrap to 7 (no load yet, both builds agree).
    tick(7);
    check("t1_zero_Q", int'(Q), 0);
    check("t1_zero_tc", int'(tc), 1);
    tick(1);
    check("t1_wrap_Q", int'(Q), 7);
    check("t1_wrap_tc", int'(tc), 0);

    // 2: count to 4, pause three edges, resume.
    tick(3);
    check("t2_at4", int'(Q), 4);
    en = 1'b0;
    tick(3);
    check("t2_pause_Q", int'(Q), 4);
    check("t2_pause_tc", int'(tc), 0);
    en = 1'b1;
    tick(1);
    check("t2_resume", int'(Q), 3);

    // 3: load beats enable on the same edge.
    load = 1'b1; load_val = 3'd5;
    tick(1);
    check("t3_load", int'(Q), 5);
    load = 1'b0;
    tick(1);
    check("t3_after", int'(Q), 4);

    // 4: one-shot from 2 into HOLD, clearing oneshot keeps HOLD, load exits.
    oneshot = 1'b1; load = 1'b1; load_val = 3'd2;
    tick(1);
    check("t4_load2", int'(Q), 2);
    load = 1'b0;
    tick(2);
    check("t4_zero_tc", int'(tc), 1);
    tick(1);
    check("t4_hold_Q", int'(Q), 0);
    check("t4_hold_done", int'(done), 1);
    check("t4_hold_tc", int'(tc), 0);
    oneshot = 1'b0;
    tick(2);
    check("t4_sticky_done", int'(done), 1);
    check("t4_sticky_Q", int'(Q), 0);
    load = 1'b1; load_val = 3'd3;
    tick(1);
    check("t4_exit_Q", int'(Q), 3);
    check("t4_exit_done", int'(done), 0);
    load = 1'b0;

    // 5: 2 ns reset pulse mid-cycle at Q=3.
    #1 reset = 1'b1;
    #1;
    check("t5_async_Q", int'(Q), 7);
    check("t5_async_done", int'(done), 0);
    #1 reset = 1'b0;
    tick(1);
    check("t5_resume1", int'(Q), 6);
    tick(1);
    check("t5_resume2", int'(Q), 5);

    // 6: wrap after loading 4 -- modulus depends on the build.
    load = 1'b1; load_val = 3'd4;
    tick(1);
    load = 1'b0;
    tick(4);
    check("t6_zero", int'(Q), 0);
    tick(1);
    check("t6_wrap", int'(Q), RELOAD_BUILD ? 4 : 7);

    // Boundary: load 0 with oneshot -> next enabled edge enters HOLD.
    oneshot = 1'b1; load = 1'b1; load_val = 3'd0;
    tick(1);
    load = 1'b0;
    check("b0_tc", int'(tc), 1);
    check("b0_done", int'(done), 0);
    tick(1);
    check("b0_hold_done", int'(done), 1);
    check("b0_hold_Q", int'(Q), 0);

    tick(2);
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
